// File: rtl/regfile_64.sv
// regfile_64: 2**ADDR_WIDTH x DATA_WIDTH integer register file, x0 hardwired to zero.
// Two combinational read ports with optional write-through, one sync write port, one debug port.
module regfile_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    output logic [DATA_WIDTH-1:0] read_data_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    output logic                  write_ignored
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  w_wr_valid;
    logic [NREG-1:0]       w_wr_sel;
    logic [DATA_WIDTH-1:0] w_file [NREG];
    logic                  w_fwd_a;
    logic                  w_fwd_b;

    assign w_wr_valid    = write_enable && (write_addr != '0);
    assign write_ignored = write_enable && (write_addr == '0);

    always_comb begin
        w_wr_sel = '0;
        if (w_wr_valid) begin
            w_wr_sel[write_addr] = 1'b1;
        end
    end

    assign w_file[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_wr_sel[i]) begin
                r_q <= write_data;
            end
        end

        assign w_file[i] = r_q;
    end

    // Forwarding is suppressed in reset so all ports read zero while rst_n is low.
    assign w_fwd_a = (BYPASS_EN != 0) && rst_n && w_wr_valid
                     && (read_addr_a == write_addr);
    assign w_fwd_b = (BYPASS_EN != 0) && rst_n && w_wr_valid
                     && (read_addr_b == write_addr);

    assign read_data_a = w_fwd_a ? write_data : w_file[read_addr_a];
    assign read_data_b = w_fwd_b ? write_data : w_file[read_addr_b];
    assign debug_data  = w_file[debug_addr];

endmodule

// File: tb/tb_regfile_64.sv
// tb_regfile_64: bypass and no-bypass instances on shared stimulus,
// checked against an array model of the architectural registers.
module tb_regfile_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra_a, ra_b, wa, da;
    logic        we;
    logic [63:0] wd;

    logic [63:0] b_rd_a, b_rd_b, b_dbg;
    logic        b_wi;
    logic [63:0] n_rd_a, n_rd_b, n_dbg;
    logic        n_wi;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_regs [32];

    always #5 clk = ~clk;

    regfile_64 #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .BYPASS_EN(1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(ra_a), .read_data_a(b_rd_a),
        .read_addr_b(ra_b), .read_data_b(b_rd_b),
        .write_enable(we), .write_addr(wa), .write_data(wd),
        .debug_addr(da), .debug_data(b_dbg),
        .write_ignored(b_wi)
    );

    regfile_64 #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .BYPASS_EN(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(ra_a), .read_data_a(n_rd_a),
        .read_addr_b(ra_b), .read_data_b(n_rd_b),
        .write_enable(we), .write_addr(wa), .write_data(wd),
        .debug_addr(da), .debug_data(n_dbg),
        .write_ignored(n_wi)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 64'd0;
        if (byp && rst_n && we && wa != 5'd0 && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic check_all(input string tag);
        logic [63:0] wi_exp;
        wi_exp = {63'd0, we && (wa == 5'd0)};
        check({tag, ".byp.a"},   b_rd_a, exp_rd(ra_a, 1'b1));
        check({tag, ".byp.b"},   b_rd_b, exp_rd(ra_b, 1'b1));
        check({tag, ".byp.dbg"}, b_dbg,  exp_rd(da, 1'b0));
        check({tag, ".byp.wi"},  {63'd0, b_wi}, wi_exp);
        check({tag, ".nob.a"},   n_rd_a, exp_rd(ra_a, 1'b0));
        check({tag, ".nob.b"},   n_rd_b, exp_rd(ra_b, 1'b0));
        check({tag, ".nob.dbg"}, n_dbg,  exp_rd(da, 1'b0));
        check({tag, ".nob.wi"},  {63'd0, n_wi}, wi_exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    endtask

    task automatic step(input string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        if (rst_n && we && wa != 5'd0) m_regs[wa] = wd;
        #1;
    endtask

    task automatic set(input logic e, input logic [4:0] w, input logic [63:0] d,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] g);
        we = e; wa = w; wd = d; ra_a = a; ra_b = b; da = g;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_model();
        set(1'b1, 5'd4, 64'h1234, 5'd4, 5'd4, 5'd4);
        @(posedge clk);
        #1;
        step("rst_hold");
        rst_n = 1'b1;

        set(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5, 5'd5, 5'd5);
        step("w5");
        set(1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 5'd5);
        #1;
        check_all("w5_stored");
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all("rst_async");
        rst_n = 1'b1;
        step("rst_rel");

        set(1'b1, 5'd1, 64'h1, 5'd0, 5'd0, 5'd1);
        step("w1");
        set(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd31);
        step("w31");
        set(1'b0, 5'd0, 64'd0, 5'd1, 5'd31, 5'd31);
        step("rd1_31");

        set(1'b1, 5'd0, 64'h55, 5'd0, 5'd0, 5'd0);
        step("x0_wr");
        set(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        step("x0_after");

        set(1'b1, 5'd7, 64'h10, 5'd0, 5'd0, 5'd0);
        step("w7a");
        set(1'b1, 5'd7, 64'h20, 5'd7, 5'd7, 5'd7);
        step("byp7");
        set(1'b0, 5'd0, 64'd0, 5'd7, 5'd7, 5'd7);
        step("byp7_after");

        set(1'b1, 5'd9, 64'hA, 5'd9, 5'd2, 5'd9);
        step("w9a");
        set(1'b1, 5'd9, 64'hB, 5'd9, 5'd9, 5'd9);
        step("w9b");
        set(1'b0, 5'd0, 64'd0, 5'd9, 5'd9, 5'd9);
        step("w9_last");

        set(1'b1, 5'd3, 64'hABCD, 5'd3, 5'd3, 5'd3);
        rst_n = 1'b0;
        clear_model();
        step("rdw");
        rst_n = 1'b1;
        step("rdw_rel");
        set(1'b0, 5'd0, 64'd0, 5'd3, 5'd3, 5'd3);
        step("rdw_store");

        for (int i = 0; i < 400; i++) begin
            logic [4:0] pa;
            pa = 5'($urandom_range(0, 31));
            set(1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0) ? pa : 5'($urandom_range(0, 31)),
                {$urandom, $urandom},
                ($urandom_range(0, 2) == 0) ? pa : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) == 0) ? pa : 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)));
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                clear_model();
                #1;
                check_all("rnd_rst");
                rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
